subset_cfg_loader: RTL and testbench
====================================

// Module: subset_cfg_loader
// PURPOSE
//   Producer side of the Subset circle-config interface. Accepts a byte stream with a
//   valid/ready handshake and parses 9-byte frames: mode, three circle centres and three
//   radii. Squares each radius sequentially, then commits the packed central,
//   radius_square and mode buses to all per-pixel Subset instances in one atomic update.
// PARAMETERS
//   SYNC_BYTE       8'hA5     frame start marker
//   TIMEOUT_CYCLES  16'd50000 max idle cycles between bytes inside a frame (>=1)
// PORTS
//   clk            in   1   system clock
//   rst_n          in   1   asynchronous active-low reset
//   in_data        in   8   stream byte
//   in_valid       in   1   in_data is valid
//   in_ready       out  1   loader can accept a byte
//   central        out  24  {xA,yA,xB,yB,xC,yC}, 4 b each, xA in [23:20] ... yC in [3:0]
//   radius_square  out  24  {rA^2,rB^2,rC^2}, 8 b each, rA^2 in [23:16]
//   mode           out  2   00 A, 01 A&B, 10 A^B, 11 exactly-two-of-three
//   cfg_valid      out  1   1 once any frame has committed; sticky until reset
//   cfg_update     out  1   1-cycle pulse in the first cycle new outputs are visible
//   frame_err      out  1   1-cycle pulse when a frame is rejected
//   busy           out  1   1 in any state other than IDLE
// BEHAVIOUR
//   Reset: central=0, radius_square=0, mode=0, cfg_valid=0, cfg_update=0,
//     frame_err=0, busy=0, in_ready=1, state=IDLE, shadow regs=0.
//   Handshake: a byte transfers on a rising edge with in_valid&in_ready. in_ready is
//     combinational from state only: 1 in IDLE/RECV, 0 otherwise.
//   Frame (byte index after sync): 0 SYNC_BYTE; 1 {6'b0,mode}; 2..4 {x,y} for A,B,C;
//     5..7 {4'b0,r} for A,B,C; 8 checksum = XOR of bytes 1..7.
//   FSM:
//     IDLE: a byte equal to SYNC_BYTE -> RECV with idx=1. Other bytes are dropped silently.
//     RECV: store each byte into the shadow at idx and increment idx. Track bad =
//       (byte1[7:2]!=0) | (any radius byte[7:4]!=0), and a running XOR.
//       On idx=8 compare the checksum; bad or mismatch -> ERR, otherwise -> SQUARE.
//       timer counts cycles with no transfer. timer==TIMEOUT_CYCLES -> ERR.
//     SQUARE: 4-bit sequential shift-add squarer, 4 cycles per radius, A then B then C
//       (12 cycles). Result is 8 b and unsigned. Max 15^2=225, so no overflow.
//     COMMIT (1 cycle): load central, radius_square and mode from the shadow at the
//       clock edge leaving COMMIT. cfg_update=1 and cfg_valid=1 in the following cycle
//       -> IDLE.
//     ERR (1 cycle): frame_err=1 in the following cycle. The shadow is discarded and
//       the outputs keep their previous values -> IDLE.
//   Latency: checksum handshake at edge T; the new outputs and cfg_update appear exactly
//     14 cycles later (1 decision + 12 square + 1 commit). frame_err appears 2 cycles
//     after the failing edge, or after the timeout.
//   Boundaries:
//     - A SYNC_BYTE value inside RECV is data, not a resync.
//     - Outputs never change except at COMMIT, so consumers never see a mixed old/new
//       config.
//     - r=0 gives radius_square=0: the circle is empty, because Subset uses strict <.
//     - Back-to-back frames: the next sync is accepted in the first IDLE cycle after
//       COMMIT or ERR.
//     - rst_n low mid-frame or mid-square: all registers return to reset values at once.
//       Committed outputs also clear to 0.
//     - in_valid held with in_ready=0 (SQUARE/COMMIT/ERR): no byte is consumed. The source
//       holds it until in_ready returns.
// STRUCTURE
//   Package subset_cfg_pkg: SYNC_BYTE default, FRAME_LEN=9, byte-index constants,
//     state encoding (IDLE, RECV, SQUARE, COMMIT, ERR), field bit positions of central
//     and radius_square (shared with Subset).
//   Sub-module sq4_seq: start pulse + 4-bit operand in -> done pulse + 8-bit square,
//     4 cycles, shift-add. Instantiated once and time-shared across A/B/C.
// TESTING
//   1. Reset, then frame A5 01 33 77 C4 03 02 05 <xor> -> cfg_update at T+14;
//      central=0x3377C4, radius_square=0x090419, mode=01, cfg_valid=1.
//   2. Same frame with the checksum off by 1 -> frame_err pulse, no cfg_update,
//      outputs stay at their prior values.
//   3. Radius byte 0x1F or mode byte 0x04 -> frame_err. Next valid frame commits normally.
//   4. Junk 00 FF 12 before sync -> ignored. A5 as data byte 2 -> stored as x=A,y=5.
//   5. Stall 50000 cycles after byte 4 -> frame_err, back to IDLE, in_ready=1.
//   6. Assert rst_n low during SQUARE after a prior commit -> all outputs 0, cfg_valid=0,
//      then a fresh frame commits correctly. Check that in_ready=0 throughout SQUARE.

Source files
------------

// File: rtl/subset_cfg_pkg.sv
// Shared constants for the Subset circle-config interface: frame layout,
// loader state encoding and the bit positions of each circle in the packed buses.
package subset_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_LEN     = 9;
  localparam int         NUM_CIRCLES   = 3;

  localparam logic [3:0] IDX_MODE  = 4'd1;
  localparam logic [3:0] IDX_CTR_A = 4'd2;
  localparam logic [3:0] IDX_CTR_C = 4'd4;
  localparam logic [3:0] IDX_RAD_A = 4'd5;
  localparam logic [3:0] IDX_RAD_C = 4'd7;
  localparam logic [3:0] IDX_CHK   = 4'd8;

  // Each circle owns one byte lane in both central ({x,y}) and radius_square.
  localparam int FIELD_W = 8;
  localparam int X_OFS   = 4;
  localparam int Y_OFS   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_SQUARE,
    ST_COMMIT,
    ST_ERR
  } state_t;

  // Circle 0 (A) sits in the top byte lane, circle 2 (C) in the bottom one.
  function automatic int field_lsb(input int circle);
    return (NUM_CIRCLES - 1 - circle) * FIELD_W;
  endfunction

endpackage

// File: rtl/subset_cfg_loader_sq4_seq.sv
// Sequential 4x4 shift-add squarer: one partial product per cycle, done pulses
// in the fourth cycle after start with the 8-bit result held until the next start.
module sq4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] operand,
  output logic       done,
  output logic [7:0] square
);

  logic [7:0] acc;
  logic [7:0] mcand;
  logic [3:0] mult;
  logic [1:0] cnt;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      mult  <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // The start cycle already folds in the bit-0 partial product.
        acc   <= operand[0] ? {4'b0, operand} : 8'd0;
        mcand <= {3'b0, operand, 1'b0};
        mult  <= {1'b0, operand[3:1]};
        cnt   <= 2'd1;
        run   <= 1'b1;
      end else if (run) begin
        acc   <= acc + (mult[0] ? mcand : 8'd0);
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        cnt   <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign square = acc;

endmodule

// File: rtl/subset_cfg_loader.sv
// Parses 9-byte circle-config frames from a byte stream, squares the radii and
// commits central/radius_square/mode to the Subset instances in one atomic update.
module subset_cfg_loader
  import subset_cfg_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] central,
  output logic [23:0] radius_square,
  output logic [1:0]  mode,
  output logic        cfg_valid,
  output logic        cfg_update,
  output logic        frame_err,
  output logic        busy
);

  state_t            state;
  logic [3:0]        idx;
  logic [15:0]       timer;
  logic [7:0]        xor_acc;
  logic              bad;
  logic              chk_err;
  logic [1:0]        mode_sh;
  logic [2:0][7:0]   ctr_sh;
  logic [2:0][3:0]   rad_sh;
  logic [2:0][7:0]   rsq_sh;
  logic              sq_run;
  logic [1:0]        sq_sel;
  logic              sq_start;
  logic [3:0]        sq_operand;
  logic              sq_done;
  logic [7:0]        sq_result;
  logic [23:0]       central_next;
  logic [23:0]       rsq_next;
  logic              xfer;

  assign in_ready = (state == ST_IDLE) || (state == ST_RECV);
  assign busy     = (state != ST_IDLE);
  assign xfer     = in_valid && in_ready;

  for (genvar gi = 0; gi < NUM_CIRCLES; gi++) begin : g_pack
    assign central_next[field_lsb(gi) + X_OFS +: 4] = ctr_sh[gi][7:4];
    assign central_next[field_lsb(gi) + Y_OFS +: 4] = ctr_sh[gi][3:0];
    assign rsq_next[field_lsb(gi) +: FIELD_W]       = rsq_sh[gi];
  end

  // The first SQUARE cycle is the accept/reject decision; each later start
  // is issued in the cycle the previous radius finishes.
  always_comb begin
    sq_start   = 1'b0;
    sq_operand = rad_sh[0];
    if (state == ST_SQUARE) begin
      if (!sq_run) begin
        sq_start = !(bad || chk_err);
      end else if (sq_done && (sq_sel != 2'd2)) begin
        sq_start   = 1'b1;
        sq_operand = rad_sh[2'(sq_sel + 2'd1)];
      end
    end
  end

  sq4_seq u_sq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (sq_start),
    .operand (sq_operand),
    .done    (sq_done),
    .square  (sq_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      timer         <= '0;
      xor_acc       <= '0;
      bad           <= 1'b0;
      chk_err       <= 1'b0;
      mode_sh       <= '0;
      ctr_sh        <= '0;
      rad_sh        <= '0;
      rsq_sh        <= '0;
      sq_run        <= 1'b0;
      sq_sel        <= '0;
      central       <= '0;
      radius_square <= '0;
      mode          <= '0;
      cfg_valid     <= 1'b0;
      cfg_update    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer && (in_data == SYNC_BYTE)) begin
            state   <= ST_RECV;
            idx     <= IDX_MODE;
            timer   <= '0;
            xor_acc <= '0;
            bad     <= 1'b0;
            chk_err <= 1'b0;
          end
        end
        ST_RECV: begin
          if (xfer) begin
            timer <= '0;
            idx   <= idx + 4'd1;
            if (idx != IDX_CHK) xor_acc <= xor_acc ^ in_data;
            if (idx == IDX_MODE) begin
              mode_sh <= in_data[1:0];
              bad     <= bad || (in_data[7:2] != 6'd0);
            end else if (idx >= IDX_CTR_A && idx <= IDX_CTR_C) begin
              ctr_sh[2'(idx - IDX_CTR_A)] <= in_data;
            end else if (idx >= IDX_RAD_A && idx <= IDX_RAD_C) begin
              rad_sh[2'(idx - IDX_RAD_A)] <= in_data[3:0];
              bad <= bad || (in_data[7:4] != 4'd0);
            end else begin
              chk_err <= (in_data != xor_acc);
              sq_run  <= 1'b0;
              sq_sel  <= '0;
              state   <= ST_SQUARE;
            end
          end else if (timer == TIMEOUT_CYCLES) begin
            state <= ST_ERR;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_SQUARE: begin
          if (!sq_run) begin
            if (bad || chk_err) state <= ST_ERR;
            else                sq_run <= 1'b1;
          end else if (sq_done) begin
            rsq_sh[sq_sel] <= sq_result;
            if (sq_sel == 2'd2) state <= ST_COMMIT;
            else                sq_sel <= sq_sel + 2'd1;
          end
        end
        ST_COMMIT: begin
          central       <= central_next;
          radius_square <= rsq_next;
          mode          <= mode_sh;
          cfg_valid     <= 1'b1;
          cfg_update    <= 1'b1;
          state         <= ST_IDLE;
        end
        ST_ERR: begin
          frame_err <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subset_cfg_loader.sv
// Randomized frame stimulus with a scoreboard: the driver pushes the predicted
// outcome of each frame, a negedge monitor pops it when cfg_update/frame_err fires.
module tb_subset_cfg_loader;

  localparam int TIMEOUT = 50000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] central;
  logic [23:0] radius_square;
  logic [1:0]  mode;
  logic        cfg_valid;
  logic        cfg_update;
  logic        frame_err;
  logic        busy;

  subset_cfg_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .central       (central),
    .radius_square (radius_square),
    .mode          (mode),
    .cfg_valid     (cfg_valid),
    .cfg_update    (cfg_update),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [7:0] frame_t [9];
  typedef struct {
    bit          is_commit;
    logic [23:0] central;
    logic [23:0] rsq;
    logic [1:0]  mode;
    int unsigned lo;
    int unsigned hi;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] cur_central = '0;
  logic [23:0] cur_rsq = '0;
  logic [1:0]  cur_mode = '0;
  logic        cur_valid = 1'b0;
  int unsigned blk_lo = 1;
  int unsigned blk_hi = 0;
  bit          mon_en = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: decides accept/reject from the frame rules and computes the
  // committed buses with plain arithmetic.
  function automatic exp_t model(input frame_t f);
    exp_t e;
    logic [7:0] x = 8'd0;
    int ra, rb, rc;
    for (int i = 1; i <= 7; i++) x ^= f[i];
    ra = f[5]; rb = f[6]; rc = f[7];
    e.is_commit = (f[1] < 4) && (ra < 16) && (rb < 16) && (rc < 16) && (f[8] == x);
    e.central   = {f[2], f[3], f[4]};
    e.rsq       = {8'(ra * ra), 8'(rb * rb), 8'(rc * rc)};
    e.mode      = f[1][1:0];
    e.lo = 0;
    e.hi = 0;
    return e;
  endfunction

  function automatic logic [7:0] fxor(input frame_t f);
    logic [7:0] x = 8'd0;
    for (int i = 1; i <= 7; i++) x ^= f[i];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, output int unsigned k);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    for (int w = 0; !in_ready; w++) begin
      if (w > 200) begin
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        break;
      end
      @(negedge clk);
    end
    k = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int gap_max);
    exp_t e;
    int unsigned k;
    e = model(f);
    for (int i = 0; i < 9; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(f[i], k);
    end
    if (e.is_commit) begin
      e.lo = k + 15; e.hi = k + 15;
      blk_lo = k + 1; blk_hi = k + 14;
    end else begin
      e.lo = k + 3; e.hi = k + 3;
      blk_lo = k + 1; blk_hi = k + 2;
    end
    sbq.push_back(e);
  endtask

  task automatic drain(input int limit);
    for (int w = 0; sbq.size() != 0; w++) begin
      if (w >= limit) begin
        check("drain_pending", 32'(sbq.size()), 32'd0);
        sbq.delete();
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] m, input logic [7:0] ca, input logic [7:0] cb,
                                        input logic [7:0] cc, input logic [7:0] ra, input logic [7:0] rb,
                                        input logic [7:0] rc);
    frame_t f;
    f[0] = 8'hA5; f[1] = m; f[2] = ca; f[3] = cb; f[4] = cc;
    f[5] = ra; f[6] = rb; f[7] = rc;
    f[8] = fxor(f);
    return f;
  endfunction

  // Monitor: pops one expectation per event and tracks the committed config.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (cfg_update || frame_err) begin
        check("single_event", {30'd0, cfg_update, frame_err} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
        if (sbq.size() == 0) begin
          check("unexpected_event", {30'd0, cfg_update, frame_err}, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("event_kind_commit", {31'd0, cfg_update}, {31'd0, e.is_commit});
          check("event_cycle", cyc, (cyc >= e.lo && cyc <= e.hi) ? cyc : e.lo);
          if (e.is_commit && cfg_update) begin
            cur_central = e.central;
            cur_rsq     = e.rsq;
            cur_mode    = e.mode;
            cur_valid   = 1'b1;
          end
        end
      end else if (sbq.size() != 0 && cyc > sbq[0].hi) begin
        e = sbq.pop_front();
        check("event_missing", {30'd0, cfg_update, frame_err}, e.is_commit ? 32'd2 : 32'd1);
      end
      check("central", {8'd0, central}, {8'd0, cur_central});
      check("radius_square", {8'd0, radius_square}, {8'd0, cur_rsq});
      check("mode", {30'd0, mode}, {30'd0, cur_mode});
      check("cfg_valid", {31'd0, cfg_valid}, {31'd0, cur_valid});
      if (cyc >= blk_lo && cyc <= blk_hi) check("in_ready_blocked", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_central"}, {8'd0, central}, 32'd0);
    check({tag, "_rsq"}, {8'd0, radius_square}, 32'd0);
    check({tag, "_mode"}, {30'd0, mode}, 32'd0);
    check({tag, "_cfg_valid"}, {31'd0, cfg_valid}, 32'd0);
    check({tag, "_cfg_update"}, {31'd0, cfg_update}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    int unsigned k;
    int corrupt;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Reference frame: centres 33 77 C4, radii 3 2 5, mode 01.
    f = make_frame(8'h01, 8'h33, 8'h77, 8'hC4, 8'h03, 8'h02, 8'h05);
    send_frame(f, 0);
    drain(40);

    // Bad checksum, then out-of-range radius and mode, then a good frame.
    f[8] = f[8] + 8'd1;
    send_frame(f, 0);
    f = make_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h1F, 8'h01, 8'h01);
    send_frame(f, 0);
    f = make_frame(8'h04, 8'h11, 8'h22, 8'h33, 8'h01, 8'h01, 8'h01);
    send_frame(f, 0);
    f = make_frame(8'h03, 8'h12, 8'h34, 8'h56, 8'h0F, 8'h00, 8'h07);
    send_frame(f, 1);
    drain(40);

    // Junk ahead of sync is dropped; A5 inside a frame is ordinary data.
    send_byte(8'h00, k); send_byte(8'hFF, k); send_byte(8'h12, k);
    f = make_frame(8'h00, 8'hA5, 8'hA5, 8'h9C, 8'h0A, 8'h05, 8'h00);
    send_frame(f, 0);
    drain(40);

    // Randomized frames, back to back or with small gaps and occasional faults.
    for (int n = 0; n < 40; n++) begin
      f = make_frame(8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
      corrupt = $urandom_range(0, 7);
      if (corrupt == 0) f[8] = f[8] ^ 8'(1 << $urandom_range(0, 7));
      if (corrupt == 1) begin f[1] = f[1] | 8'(4 << $urandom_range(0, 5)); f[8] = fxor(f); end
      if (corrupt == 2) begin f[6] = f[6] | 8'(16 << $urandom_range(0, 3)); f[8] = fxor(f); end
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'($urandom_range(0, 8'hA4)), k);
      end
      send_frame(f, $urandom_range(0, 1) * 3);
    end
    drain(400);

    // Stall mid-frame until the inter-byte timeout fires.
    f = make_frame(8'h01, 8'h44, 8'h55, 8'h66, 8'h01, 8'h02, 8'h03);
    for (int i = 0; i <= 4; i++) send_byte(f[i], k);
    begin
      exp_t e;
      e = model(f);
      e.is_commit = 1'b0;
      e.lo = k + TIMEOUT;
      e.hi = k + TIMEOUT + 5;
      sbq.push_back(e);
    end
    drain(TIMEOUT + 50);
    @(negedge clk);
    check("timeout_in_ready", {31'd0, in_ready}, 32'd1);
    check("timeout_busy", {31'd0, busy}, 32'd0);

    // Reset while squaring wipes committed outputs; a fresh frame then commits.
    f = make_frame(8'h02, 8'h98, 8'h76, 8'h54, 8'h0C, 8'h0D, 8'h0E);
    send_frame(f, 0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    sbq.delete();
    cur_central = '0; cur_rsq = '0; cur_mode = '0; cur_valid = 1'b0;
    blk_lo = 1; blk_hi = 0;
    @(negedge clk);
    check_reset_outputs("midsq_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    f = make_frame(8'h03, 8'h0F, 8'hF0, 8'h5A, 8'h09, 8'h00, 8'h0B);
    send_frame(f, 0);
    drain(40);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
